// File: rtl/viterbi_ctrl_pkg.sv
// Shared types and constants for the Viterbi frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package viterbi_ctrl_pkg;

  // Symbol width shared with the BMU input
  localparam int SYM_W = 2;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_TB    = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/viterbi_ctrl_timer.sv
// Loadable up-counter with clear/enable and terminal-count flag (traceback watchdog).
// Latency: o_tc is combinational from the count register; count updates on the clock edge.
// Backpressure: none; clear wins over load, load wins over enable, count saturates at TERM.
module viterbi_ctrl_timer #(
  parameter int          W    = 7,
  parameter int unsigned TERM = 63
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Count register: clear, load, or advance while enabled, holding at the terminal value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != W'(TERM))) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc = (r_cnt == W'(TERM));

endmodule

// File: rtl/viterbi_ctrl.sv
// Frame sequencer: feeds PISO symbols to the BMU, strobes ACS per symbol, launches and supervises traceback.
// Latency: bmu_data_o/acs_en_o one cycle after each accept; done_o one cycle after tb_done_i.
// Backpressure: sym_ready_o high only in RUN and not during abort; symbols outside RUN are left unconsumed.
module viterbi_ctrl
  import viterbi_ctrl_pkg::*;
#(
  parameter int FRAME_LEN  = 8,
  parameter int CNT_W      = 8,
  parameter int TB_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             sym_valid_i,
  input  logic [SYM_W-1:0] sym_data_i,
  output logic             sym_ready_o,
  output logic [SYM_W-1:0] bmu_data_o,
  output logic             acs_en_o,
  output logic             pm_init_o,
  output logic [CNT_W-1:0] step_cnt_o,
  output logic             tb_start_o,
  input  logic             tb_done_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int WD_W = $clog2(TB_TIMEOUT + 1);

  state_t           r_state;
  logic [SYM_W-1:0] r_bmu_data;
  logic [CNT_W-1:0] r_step;
  logic             r_acs_en;
  logic             r_pm_init;
  logic             r_tb_start;
  logic             r_done;
  logic             r_err;

  logic             w_run;
  logic             w_accept;
  logic             w_last;
  logic             w_tb_done;
  logic             w_wd_tc;

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = w_run && sym_valid_i && !abort_i;
  assign w_last   = (r_step == CNT_W'(FRAME_LEN - 1));
  // tb_done_i is not honoured in the launch cycle (r_tb_start marks it)
  assign w_tb_done = (r_state == ST_TB) && !r_tb_start && tb_done_i;

  // Watchdog: cleared while draining, counts every cycle spent in TB
  viterbi_ctrl_timer #(
    .W    (WD_W),
    .TERM (TB_TIMEOUT - 1)
  ) u_wd (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_clr      (r_state == ST_DRAIN),
    .i_en       (r_state == ST_TB),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_tc       (w_wd_tc)
  );

  // Sequencer FSM with registered strobes; abort overrides every other event
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_bmu_data <= '0;
      r_step     <= '0;
      r_acs_en   <= 1'b0;
      r_pm_init  <= 1'b0;
      r_tb_start <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (abort_i) begin
      r_state    <= ST_IDLE;
      r_acs_en   <= 1'b0;
      r_pm_init  <= 1'b0;
      r_tb_start <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state   <= ST_INIT;
            r_pm_init <= 1'b1;
            r_err     <= 1'b0;
            r_step    <= '0;
          end
        end
        ST_INIT: begin
          r_pm_init <= 1'b0;
          r_state   <= ST_RUN;
        end
        ST_RUN: begin
          r_acs_en <= w_accept;
          if (w_accept) begin
            r_bmu_data <= sym_data_i;
            if (r_step != CNT_W'(FRAME_LEN)) begin
              r_step <= r_step + CNT_W'(1);
            end
            if (w_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          r_acs_en   <= 1'b0;
          r_tb_start <= 1'b1;
          r_state    <= ST_TB;
        end
        ST_TB: begin
          r_tb_start <= 1'b0;
          if (w_tb_done) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_wd_tc) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sym_ready_o = w_run && !abort_i;
  assign bmu_data_o  = r_bmu_data;
  assign acs_en_o    = r_acs_en;
  assign pm_init_o   = r_pm_init;
  assign step_cnt_o  = r_step;
  assign tb_start_o  = r_tb_start;
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Self-checking bench for viterbi_ctrl: random and table-driven frames against a frame-level model.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: the model decides acceptance from its own view of the frame phase.
module tb_viterbi_ctrl;

  localparam int FL = 8;
  localparam int TO = 64;

  logic       clk_i       = 1'b0;
  logic       rst_ni      = 1'b0;
  logic       start_i     = 1'b0;
  logic       abort_i     = 1'b0;
  logic       sym_valid_i = 1'b0;
  logic [1:0] sym_data_i  = 2'b00;
  logic       tb_done_i   = 1'b0;
  logic       sym_ready_o;
  logic [1:0] bmu_data_o;
  logic       acs_en_o;
  logic       pm_init_o;
  logic [7:0] step_cnt_o;
  logic       tb_start_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int n_err = 0;
  int n_chk = 0;

  logic [1:0] nom_syms [FL] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10};

  always #5 clk_i = ~clk_i;

  viterbi_ctrl #(
    .FRAME_LEN  (FL),
    .CNT_W      (8),
    .TB_TIMEOUT (TO)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .sym_valid_i (sym_valid_i),
    .sym_data_i  (sym_data_i),
    .sym_ready_o (sym_ready_o),
    .bmu_data_o  (bmu_data_o),
    .acs_en_o    (acs_en_o),
    .pm_init_o   (pm_init_o),
    .step_cnt_o  (step_cnt_o),
    .tb_start_o  (tb_start_o),
    .tb_done_i   (tb_done_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_rdy"}, sym_ready_o, 0);
    chk({tag, "_acs"}, acs_en_o, 0);
    chk({tag, "_pm"}, pm_init_o, 0);
    chk({tag, "_tbs"}, tb_start_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  // One full frame. mode: 0 = nominal table back-to-back, 1 = alternate-cycle valid, 2 = random valid.
  // tb_wait: cycles after tb_start_o before tb_done_i (-1 = never). tb_done_i is also pulsed in
  // the launch cycle, where it must be ignored. poke_start pulses start_i mid-RUN.
  task automatic run_frame(input int mode, input int tb_wait, input bit poke_start);
    int         acc      = 0;
    int         cyc      = 0;
    bit         prev_acc = 1'b0;
    logic [1:0] prev_sym = 2'b00;
    bit         v;
    bit         finished = 1'b0;

    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("init_pm", pm_init_o, 1);
    chk("init_rdy", sym_ready_o, 0);
    chk("init_busy", busy_o, 1);
    chk("init_err", err_o, 0);
    chk("init_cnt", step_cnt_o, 0);
    tick();
    chk("run_pm", pm_init_o, 0);

    while (acc < FL) begin
      chk("run_rdy", sym_ready_o, 1);
      chk("run_acs", acs_en_o, 32'(prev_acc));
      if (prev_acc) chk("run_bmu", bmu_data_o, 32'(prev_sym));
      chk("run_cnt", step_cnt_o, acc);
      chk("run_tbs", tb_start_o, 0);
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 1) == 1) || (cyc % 4 == 3);
      endcase
      sym_valid_i = v;
      sym_data_i  = (mode == 0) ? nom_syms[acc] : 2'($urandom_range(0, 3));
      start_i     = poke_start && (cyc == 2);
      prev_acc    = v;
      prev_sym    = sym_data_i;
      if (v) acc++;
      cyc++;
      tick();
    end
    sym_valid_i = 1'b0;
    start_i     = 1'b0;

    // Drain: strobe for the last symbol, no more acceptance
    chk("drain_acs", acs_en_o, 1);
    chk("drain_bmu", bmu_data_o, 32'(prev_sym));
    chk("drain_rdy", sym_ready_o, 0);
    chk("drain_cnt", step_cnt_o, FL);
    chk("drain_tbs", tb_start_o, 0);
    tick();

    for (int k = 1; k <= TO && !finished; k++) begin
      chk("tb_start", tb_start_o, 32'(k == 1));
      chk("tb_acs", acs_en_o, 0);
      chk("tb_done", done_o, 0);
      chk("tb_busy", busy_o, 1);
      chk("tb_err", err_o, 0);
      tb_done_i = (k == 1) || (tb_wait >= 0 && k == tb_wait + 1);
      tick();
      if (tb_done_i && k > 1) begin
        tb_done_i = 1'b0;
        chk("done_pulse", done_o, 1);
        chk("done_err", err_o, 0);
        chk("done_cnt", step_cnt_o, FL);
        tick();
        chk("post_done", done_o, 0);
        chk("post_busy", busy_o, 0);
        chk("post_cnt", step_cnt_o, FL);
        finished = 1'b1;
      end
      tb_done_i = 1'b0;
    end

    if (!finished) begin
      chk("to_err", err_o, 1);
      chk("to_busy", busy_o, 0);
      chk("to_done", done_o, 0);
      chk("to_cnt", step_cnt_o, FL);
      tick();
      chk("to_err_hold", err_o, 1);
      chk("to_done_hold", done_o, 0);
    end
  endtask

  initial begin
    logic [1:0] last_sym;

    // Reset, then idle with no start
    #12;
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", step_cnt_o, 0);
    chk("rst_bmu", bmu_data_o, 0);
    chk("rst_err", err_o, 0);
    chk_quiet("rst");
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_quiet("idle");
      chk("idle_err", err_o, 0);
    end

    // Nominal frame, gapped frame, random frames
    run_frame(0, 5, 1'b0);
    run_frame(1, 5, 1'b0);
    for (int i = 0; i < 3; i++) run_frame(2, int'($urandom_range(1, 20)), 1'b0);

    // Watchdog timeout, then restart clears the error
    run_frame(2, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_idle_err", err_o, 1);
      chk_quiet("to_idle");
    end
    run_frame(0, 5, 1'b0);

    // tb_done_i on the same edge as the timeout; start_i during RUN
    run_frame(0, TO - 1, 1'b0);
    run_frame(1, 2, 1'b1);

    // Abort after the third accept with a symbol still offered
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    sym_valid_i = 1'b1;
    last_sym    = 2'b00;
    for (int i = 0; i < 3; i++) begin
      sym_data_i = 2'($urandom_range(0, 3));
      last_sym   = sym_data_i;
      tick();
    end
    chk("ab_pre_cnt", step_cnt_o, 3);
    chk("ab_pre_acs", acs_en_o, 1);
    sym_data_i = ~last_sym;
    abort_i    = 1'b1;
    #1;
    chk("ab_rdy_gated", sym_ready_o, 0);
    tick();
    abort_i     = 1'b0;
    sym_valid_i = 1'b0;
    chk("ab_busy", busy_o, 0);
    chk("ab_cnt", step_cnt_o, 3);
    chk("ab_bmu", bmu_data_o, 32'(last_sym));
    chk("ab_acs", acs_en_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_quiet("ab_idle");
      chk("ab_idle_cnt", step_cnt_o, 3);
    end

    // Asynchronous reset while in traceback
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    sym_valid_i = 1'b1;
    for (int i = 0; i < FL; i++) begin
      sym_data_i = 2'($urandom_range(0, 3));
      tick();
    end
    sym_valid_i = 1'b0;
    tick();
    chk("rtb_tbs", tb_start_o, 1);
    tick();
    tick();
    chk("rtb_busy_pre", busy_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rtb_busy", busy_o, 0);
    chk("rtb_cnt", step_cnt_o, 0);
    chk("rtb_bmu", bmu_data_o, 0);
    chk("rtb_err", err_o, 0);
    chk_quiet("rtb");
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_quiet("rtb_idle");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
